dwc_upconv_aw_split: RTL and testbench
======================================

Name: dwc_upconv_aw_split

Overview:
- Write-address stage of the data-width up converter: narrow master side, wide slave side.
- Accepts master AW, converts burst length/size to the wide slave data width, and splits multi-beat FIXED bursts into single-beat slave transactions.
- For every slave AW issued, pushes one command entry {more_flag, AWID} into the B-channel command FIFO. The B-response stage downstream uses this entry to absorb non-final responses and return one merged master B per original transaction.

Parameters:
- ID_WIDTH, 1, AXI ID width.
- ADDR_WIDTH, 32, AXI address width.
- USER_WIDTH, 1, AWUSER width.
- MASTER_DATA_WIDTH, 32, master data width in bits (power of 2, ≥8).
- SLAVE_DATA_WIDTH, 64, slave data width in bits (power of 2, > MASTER_DATA_WIDTH).

Ports:
- ACLK  in  1  clock.
- sysReset  in  1  synchronous active-high reset.
- MASTER_AWID  in  ID_WIDTH  transaction ID.
- MASTER_AWADDR  in  ADDR_WIDTH  start address.
- MASTER_AWLEN  in  8  beats-1.
- MASTER_AWSIZE  in  3  log2 bytes per beat.
- MASTER_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
- MASTER_AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION  in  1/4/3/4/4  sideband.
- MASTER_AWUSER  in  USER_WIDTH  user.
- MASTER_AWVALID  in  1 / MASTER_AWREADY  out  1  handshake.
- SLAVE_AWID, SLAVE_AWADDR, SLAVE_AWLEN, SLAVE_AWSIZE, SLAVE_AWBURST, sideband, SLAVE_AWUSER  out  same widths as master.
- SLAVE_AWVALID  out  1 / SLAVE_AWREADY  in  1  handshake.
- bchan_cmd_fifo_full  in  1  command FIFO nearly-full; guarantees room for one more write.
- wr_en_cmd  out  1  command FIFO push strobe.
- BRespFifoWrData  out  ID_WIDTH+1  bit ID_WIDTH = more_flag; [ID_WIDTH-1:0] = ID.

Behaviour:
- One clock ACLK; sysReset synchronous, active-high.
- Reset values: state IDLE, MASTER_AWREADY=0 during reset, SLAVE_AWVALID=0, wr_en_cmd=0, all SLAVE_AW* registers 0, BRespFifoWrData=0.
- Reset mid-operation aborts any pending/split transaction; no further slave AW or FIFO push is issued for it.
- Constants: SS = log2(SLAVE_DATA_WIDTH/8), SB = SLAVE_DATA_WIDTH/8.
- States:
  - IDLE: MASTER_AWREADY = !bchan_cmd_fifo_full. On MASTER_AWVALID&&MASTER_AWREADY, register the converted command and remaining count, then go to ISSUE with SLAVE_AWVALID=1 next cycle. Latency: master handshake at cycle N gives SLAVE_AWVALID at N+1.
  - ISSUE: SLAVE_AWVALID=1 and all SLAVE_AW* stable until SLAVE_AWREADY. On the slave handshake, wr_en_cmd=1 in the same cycle, with BRespFifoWrData={remaining!=0, ID}. Then:
    - If remaining==0: go to IDLE.
    - Else if !bchan_cmd_fifo_full: decrement remaining and stay in ISSUE, valid held high, back-to-back.
    - Else: decrement remaining and go to HOLD with SLAVE_AWVALID=0.
  - HOLD: wait for !bchan_cmd_fifo_full, then go to ISSUE with SLAVE_AWVALID=1.
- SLAVE_AWVALID is never withdrawn before its handshake. Its assertion is gated only at the IDLE→ISSUE and HOLD→ISSUE transitions.
- MASTER_AWREADY=0 in ISSUE and HOLD: one outstanding master command inside the block. Minimum 2 cycles per unsplit transaction.
- ID, sideband and USER pass through registered and unchanged to every sub-transaction.
- Conversion:
  - Notation: A=AWADDR, L=AWLEN, S=AWSIZE, bytes=(L+1)<<S, Aal=A with low S bits cleared.
  - L==0, any burst: one slave beat; ADDR=A, LEN=0, SIZE=S, BURST=INCR.
  - INCR, L>0: ADDR=A, SIZE=SS, BURST=INCR, LEN=((Aal+bytes-1)>>SS)-(A>>SS). Compute in ADDR_WIDTH+1 bits to avoid carry loss.
  - WRAP with bytes>SB: ADDR=A, SIZE=SS, BURST=WRAP, LEN=bytes/SB-1.
  - WRAP with bytes≤SB: ADDR=A, LEN=0, SIZE=SS, BURST=INCR.
  - FIXED, L>0: L+1 sub-transactions, each with ADDR=A, LEN=0, SIZE=S, BURST=INCR. remaining=L.
- more_flag is 1 on every non-final sub-transaction and 0 on the final one (and on all unsplit transactions).
- Exactly one wr_en_cmd pulse per slave AW handshake; never asserted otherwise.

Test Plan:
- Reset released, MASTER_AWVALID=1 in the same cycle as bchan_cmd_fifo_full=1 → MASTER_AWREADY=0 and no SLAVE_AWVALID. Drop full → accepted next cycle; SLAVE_AWVALID one cycle after the master handshake.
- INCR A=0x104 L=3 S=2 (32→64) → single slave AW with ADDR=0x104, LEN=2, SIZE=3, BURST=INCR; wr_en_cmd once, BRespFifoWrData={0,ID}.
- FIXED A=0x200 L=3 S=2 ID=1, SLAVE_AWREADY=1 → 4 back-to-back slave AWs, each ADDR=0x200, LEN=0, SIZE=2; more_flag 1,1,1,0. Repeat with full=1 after the 2nd push → HOLD with valid low; resumes when full clears; total still 4 pushes.
- WRAP A=0x108 L=3 S=2 → WRAP, LEN=1, SIZE=3, ADDR=0x108. WRAP A=0x104 L=1 S=2 → INCR, LEN=0, SIZE=3.
- SLAVE_AWREADY held low 5 cycles → SLAVE_AW* and valid stable throughout, wr_en_cmd=0 until the handshake.
- sysReset asserted mid-FIXED split (after 2 of 4 pushes) → next cycle SLAVE_AWVALID=0, no further pushes, block returns to IDLE accepting a new command after reset.

Source files
------------

// File: rtl/dwc_upconv_aw_split.sv
// Write-address stage of the narrow-to-wide AXI up converter: converts AW length/size
// to the slave width, splits multi-beat FIXED bursts and feeds the B-channel command FIFO.
module dwc_upconv_aw_split #(
  parameter int ID_WIDTH          = 1,
  parameter int ADDR_WIDTH        = 32,
  parameter int USER_WIDTH        = 1,
  parameter int MASTER_DATA_WIDTH = 32,
  parameter int SLAVE_DATA_WIDTH  = 64
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic [ID_WIDTH-1:0]   MASTER_AWID,
  input  logic [ADDR_WIDTH-1:0] MASTER_AWADDR,
  input  logic [7:0]            MASTER_AWLEN,
  input  logic [2:0]            MASTER_AWSIZE,
  input  logic [1:0]            MASTER_AWBURST,
  input  logic                  MASTER_AWLOCK,
  input  logic [3:0]            MASTER_AWCACHE,
  input  logic [2:0]            MASTER_AWPROT,
  input  logic [3:0]            MASTER_AWQOS,
  input  logic [3:0]            MASTER_AWREGION,
  input  logic [USER_WIDTH-1:0] MASTER_AWUSER,
  input  logic                  MASTER_AWVALID,
  output logic                  MASTER_AWREADY,
  output logic [ID_WIDTH-1:0]   SLAVE_AWID,
  output logic [ADDR_WIDTH-1:0] SLAVE_AWADDR,
  output logic [7:0]            SLAVE_AWLEN,
  output logic [2:0]            SLAVE_AWSIZE,
  output logic [1:0]            SLAVE_AWBURST,
  output logic                  SLAVE_AWLOCK,
  output logic [3:0]            SLAVE_AWCACHE,
  output logic [2:0]            SLAVE_AWPROT,
  output logic [3:0]            SLAVE_AWQOS,
  output logic [3:0]            SLAVE_AWREGION,
  output logic [USER_WIDTH-1:0] SLAVE_AWUSER,
  output logic                  SLAVE_AWVALID,
  input  logic                  SLAVE_AWREADY,
  input  logic                  bchan_cmd_fifo_full,
  output logic                  wr_en_cmd,
  output logic [ID_WIDTH:0]     BRespFifoWrData
);

  localparam int SB  = SLAVE_DATA_WIDTH / 8;
  localparam int SS  = $clog2(SB);
  localparam int AW1 = ADDR_WIDTH + 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  lock_q, lock_d;
  logic [3:0]            cache_q, cache_d;
  logic [2:0]            prot_q, prot_d;
  logic [3:0]            qos_q, qos_d;
  logic [3:0]            region_q, region_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  valid_q, valid_d;
  logic [7:0]            remaining_q, remaining_d;

  logic [AW1-1:0] a_wide_s, bytes_s, aal_s, end_s;
  logic [7:0]     incr_len_s, wrap_len_s;
  logic [7:0]     conv_len_s, split_rem_s;
  logic [2:0]     conv_size_s;
  logic [1:0]     conv_burst_s;
  logic           master_ready_s, master_hs_s, slave_valid_s, slave_hs_s;

  // Wide-address arithmetic so the end-of-burst address never loses its carry.
  always_comb begin
    a_wide_s   = {1'b0, MASTER_AWADDR};
    bytes_s    = (AW1'(MASTER_AWLEN) + AW1'(1)) << MASTER_AWSIZE;
    aal_s      = a_wide_s & ~((AW1'(1) << MASTER_AWSIZE) - AW1'(1));
    end_s      = aal_s + bytes_s - AW1'(1);
    incr_len_s = 8'((end_s >> SS) - (a_wide_s >> SS));
    wrap_len_s = 8'((bytes_s >> SS) - AW1'(1));
  end

  // Converted slave command for the master AW currently presented.
  always_comb begin
    conv_len_s   = 8'd0;
    conv_size_s  = MASTER_AWSIZE;
    conv_burst_s = BURST_INCR;
    split_rem_s  = 8'd0;
    if (MASTER_AWLEN == 8'd0) begin
      conv_len_s = 8'd0;
    end else begin
      case (MASTER_AWBURST)
        BURST_FIXED: begin
          split_rem_s = MASTER_AWLEN;
        end
        BURST_WRAP: begin
          conv_size_s = 3'(SS);
          if (bytes_s > AW1'(SB)) begin
            conv_len_s   = wrap_len_s;
            conv_burst_s = BURST_WRAP;
          end else begin
            conv_len_s   = 8'd0;
            conv_burst_s = BURST_INCR;
          end
        end
        default: begin
          conv_size_s = 3'(SS);
          conv_len_s  = incr_len_s;
        end
      endcase
    end
  end

  assign master_ready_s = (state_q == ST_IDLE) && !bchan_cmd_fifo_full && !sysReset;
  assign master_hs_s    = MASTER_AWVALID && master_ready_s;
  // Reset masks the held valid at once so an aborted split cannot complete a handshake.
  assign slave_valid_s  = valid_q && !sysReset;
  assign slave_hs_s     = slave_valid_s && SLAVE_AWREADY;

  // Next-state, command capture and split sequencing.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    lock_d      = lock_q;
    cache_d     = cache_q;
    prot_d      = prot_q;
    qos_d       = qos_q;
    region_d    = region_q;
    user_d      = user_q;
    valid_d     = valid_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (master_hs_s) begin
          id_d        = MASTER_AWID;
          addr_d      = MASTER_AWADDR;
          len_d       = conv_len_s;
          size_d      = conv_size_s;
          burst_d     = conv_burst_s;
          lock_d      = MASTER_AWLOCK;
          cache_d     = MASTER_AWCACHE;
          prot_d      = MASTER_AWPROT;
          qos_d       = MASTER_AWQOS;
          region_d    = MASTER_AWREGION;
          user_d      = MASTER_AWUSER;
          remaining_d = split_rem_s;
          valid_d     = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (!slave_hs_s) begin
          valid_d = 1'b1;
        end else if (remaining_q == 8'd0) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (!bchan_cmd_fifo_full) begin
          remaining_d = remaining_q - 8'd1;
          valid_d     = 1'b1;
        end else begin
          remaining_d = remaining_q - 8'd1;
          valid_d     = 1'b0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bchan_cmd_fifo_full) begin
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and slave AW registers.
  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'd0;
      lock_q      <= 1'b0;
      cache_q     <= 4'd0;
      prot_q      <= 3'd0;
      qos_q       <= 4'd0;
      region_q    <= 4'd0;
      user_q      <= '0;
      valid_q     <= 1'b0;
      remaining_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      lock_q      <= lock_d;
      cache_q     <= cache_d;
      prot_q      <= prot_d;
      qos_q       <= qos_d;
      region_q    <= region_d;
      user_q      <= user_d;
      valid_q     <= valid_d;
      remaining_q <= remaining_d;
    end
  end

  assign MASTER_AWREADY  = master_ready_s;
  assign SLAVE_AWVALID   = slave_valid_s;
  assign SLAVE_AWID      = id_q;
  assign SLAVE_AWADDR    = addr_q;
  assign SLAVE_AWLEN     = len_q;
  assign SLAVE_AWSIZE    = size_q;
  assign SLAVE_AWBURST   = burst_q;
  assign SLAVE_AWLOCK    = lock_q;
  assign SLAVE_AWCACHE   = cache_q;
  assign SLAVE_AWPROT    = prot_q;
  assign SLAVE_AWQOS     = qos_q;
  assign SLAVE_AWREGION  = region_q;
  assign SLAVE_AWUSER    = user_q;
  assign wr_en_cmd       = slave_hs_s;
  assign BRespFifoWrData = slave_hs_s ? {(remaining_q != 8'd0), id_q} : '0;

endmodule

// File: tb/tb_dwc_upconv_aw_split.sv
// Scoreboard bench for dwc_upconv_aw_split: directed master AWs push expected slave AWs,
// a negedge monitor pops and compares on every slave handshake.
module tb_dwc_upconv_aw_split;

  logic        clk;
  logic        rst;
  logic [0:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic        m_lock;
  logic [3:0]  m_cache;
  logic [2:0]  m_prot;
  logic [3:0]  m_qos;
  logic [3:0]  m_region;
  logic [0:0]  m_user;
  logic        m_valid;
  logic        m_ready;
  logic [0:0]  s_id;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [2:0]  s_size;
  logic [1:0]  s_burst;
  logic        s_lock;
  logic [3:0]  s_cache;
  logic [2:0]  s_prot;
  logic [3:0]  s_qos;
  logic [3:0]  s_region;
  logic [0:0]  s_user;
  logic        s_valid;
  logic        s_ready;
  logic        full;
  logic        wr_en;
  logic [1:0]  bdata;

  dwc_upconv_aw_split #(
    .ID_WIDTH(1), .ADDR_WIDTH(32), .USER_WIDTH(1),
    .MASTER_DATA_WIDTH(32), .SLAVE_DATA_WIDTH(64)
  ) dut (
    .ACLK(clk), .sysReset(rst),
    .MASTER_AWID(m_id), .MASTER_AWADDR(m_addr), .MASTER_AWLEN(m_len),
    .MASTER_AWSIZE(m_size), .MASTER_AWBURST(m_burst), .MASTER_AWLOCK(m_lock),
    .MASTER_AWCACHE(m_cache), .MASTER_AWPROT(m_prot), .MASTER_AWQOS(m_qos),
    .MASTER_AWREGION(m_region), .MASTER_AWUSER(m_user),
    .MASTER_AWVALID(m_valid), .MASTER_AWREADY(m_ready),
    .SLAVE_AWID(s_id), .SLAVE_AWADDR(s_addr), .SLAVE_AWLEN(s_len),
    .SLAVE_AWSIZE(s_size), .SLAVE_AWBURST(s_burst), .SLAVE_AWLOCK(s_lock),
    .SLAVE_AWCACHE(s_cache), .SLAVE_AWPROT(s_prot), .SLAVE_AWQOS(s_qos),
    .SLAVE_AWREGION(s_region), .SLAVE_AWUSER(s_user),
    .SLAVE_AWVALID(s_valid), .SLAVE_AWREADY(s_ready),
    .bchan_cmd_fifo_full(full), .wr_en_cmd(wr_en), .BRespFifoWrData(bdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        id;
    logic        more;
    logic [16:0] sb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_count = 0;
  int   seq      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every slave handshake is matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("valid_in_reset", 64'(s_valid), 64'd0);
    end else begin
      check("wr_en_vs_handshake", 64'(wr_en), 64'(s_valid && s_ready));
      if (s_valid && s_ready) begin
        hs_count++;
        if (q.size() == 0) begin
          check("unexpected_slave_aw", 64'(s_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("aw_addr", 64'(s_addr), 64'(e.addr));
          check("aw_len", 64'(s_len), 64'(e.len));
          check("aw_size", 64'(s_size), 64'(e.size));
          check("aw_burst", 64'(s_burst), 64'(e.burst));
          check("aw_id", 64'(s_id), 64'(e.id));
          check("bresp_data", 64'(bdata), 64'({e.more, e.id}));
          check("aw_sideband", 64'({s_lock, s_cache, s_prot, s_qos, s_region, s_user}), 64'(e.sb));
        end
      end
    end
  end

  // Drive a master AW and queue n_push expected slave AWs out of n_total sub-transactions.
  task automatic drive_aw(input logic id, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b,
                          input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es,
                          input logic [1:0] eb, input int n_push, input int n_total);
    logic [16:0] sb;
    exp_t e;
    seq++;
    sb = 17'(seq * 12345 + 7);
    for (int i = 0; i < n_push; i++) begin
      e.addr = ea; e.len = el; e.size = es; e.burst = eb; e.id = id;
      e.more = (i < n_total - 1); e.sb = sb;
      q.push_back(e);
    end
    m_id = id; m_addr = a; m_len = l; m_size = s; m_burst = b;
    {m_lock, m_cache, m_prot, m_qos, m_region, m_user} = sb;
    m_valid = 1'b1;
  endtask

  // Complete the master handshake of the AW currently driven; returns 1 ns after that edge.
  task automatic finish_aw();
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("awready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  task automatic send(input logic id, input logic [31:0] a, input logic [7:0] l,
                      input logic [2:0] s, input logic [1:0] b,
                      input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es,
                      input logic [1:0] eb, input int n);
    @(posedge clk); #1;
    drive_aw(id, a, l, s, b, ea, el, es, eb, n, n);
    finish_aw();
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !s_valid) begin
        done = 1;
        break;
      end
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; full = 1'b1; s_ready = 1'b1; m_valid = 1'b0;
    m_id = 1'b0; m_addr = 32'd0; m_len = 8'd0; m_size = 3'd0; m_burst = 2'd0;
    {m_lock, m_cache, m_prot, m_qos, m_region, m_user} = 17'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_awready", 64'(m_ready), 64'd0);
    check("reset_awvalid", 64'(s_valid), 64'd0);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_bdata", 64'(bdata), 64'd0);
    check("reset_addr", 64'(s_addr), 64'd0);

    // Release reset with a pending AW while the command FIFO reports full.
    @(posedge clk); #1;
    rst = 1'b0;
    drive_aw(1'b0, 32'h104, 8'd3, 3'd2, 2'b01, 32'h104, 8'd2, 3'd3, 2'b01, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_blocks_awready", 64'(m_ready), 64'd0);
      check("full_no_awvalid", 64'(s_valid), 64'd0);
      @(posedge clk); #1;
    end
    full = 1'b0;
    @(negedge clk);
    check("awready_after_full_clear", 64'(m_ready), 64'd1);
    check("awvalid_before_hs", 64'(s_valid), 64'd0);
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(negedge clk);
    check("awvalid_latency", 64'(s_valid), 64'd1);
    check("awready_low_in_issue", 64'(m_ready), 64'd0);
    drain("drain_incr");

    // FIXED split, slave always ready: four back-to-back sub-transactions.
    base = hs_count;
    send(1'b1, 32'h200, 8'd3, 3'd2, 2'b00, 32'h200, 8'd0, 3'd2, 2'b01, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fixed_back_to_back", 64'(s_valid && wr_en), 64'd1);
    end
    @(negedge clk);
    check("fixed_done_valid_low", 64'(s_valid), 64'd0);
    check("fixed_push_count", 64'(hs_count - base), 64'd4);
    drain("drain_fixed");

    // FIXED split with the FIFO filling after the second push.
    base = hs_count;
    send(1'b1, 32'h200, 8'd3, 3'd2, 2'b00, 32'h200, 8'd0, 3'd2, 2'b01, 4);
    @(posedge clk); #1;
    full = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_valid_low", 64'(s_valid), 64'd0);
    end
    check("hold_push_count", 64'(hs_count - base), 64'd2);
    @(posedge clk); #1;
    full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold_resume_valid", 64'(s_valid), 64'd1);
    drain("drain_hold");
    check("hold_total_pushes", 64'(hs_count - base), 64'd4);

    // WRAP conversions, either side of one slave beat.
    send(1'b0, 32'h108, 8'd3, 3'd2, 2'b10, 32'h108, 8'd1, 3'd3, 2'b10, 1);
    drain("drain_wrap_big");
    send(1'b1, 32'h104, 8'd1, 3'd2, 2'b10, 32'h104, 8'd0, 3'd3, 2'b01, 1);
    drain("drain_wrap_small");
    // Single-beat WRAP/FIXED pass SIZE through; unaligned INCR straddles a slave beat.
    send(1'b0, 32'h012, 8'd0, 3'd1, 2'b10, 32'h012, 8'd0, 3'd1, 2'b01, 1);
    drain("drain_len0_wrap");
    send(1'b1, 32'h300, 8'd0, 3'd2, 2'b00, 32'h300, 8'd0, 3'd2, 2'b01, 1);
    drain("drain_len0_fixed");
    send(1'b1, 32'h106, 8'd1, 3'd2, 2'b01, 32'h106, 8'd1, 3'd3, 2'b01, 1);
    drain("drain_incr_unaligned");

    // Slave back-pressure: AW stays stable and no push until the handshake.
    s_ready = 1'b0;
    send(1'b0, 32'h104, 8'd3, 3'd2, 2'b01, 32'h104, 8'd2, 3'd3, 2'b01, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(s_valid), 64'd1);
      check("stall_addr", 64'(s_addr), 64'h104);
      check("stall_len", 64'(s_len), 64'd2);
      check("stall_no_push", 64'(wr_en), 64'd0);
    end
    s_ready = 1'b1;
    drain("drain_stall");

    // Reset in the middle of a FIXED split after two pushes.
    base = hs_count;
    @(posedge clk); #1;
    drive_aw(1'b1, 32'h400, 8'd3, 3'd2, 2'b00, 32'h400, 8'd0, 3'd2, 2'b01, 2, 4);
    finish_aw();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_valid", 64'(s_valid), 64'd0);
    check("reset_mid_wr_en", 64'(wr_en), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("after_reset_idle", 64'(s_valid), 64'd0);
    end
    check("reset_mid_pushes", 64'(hs_count - base), 64'd2);
    check("reset_mid_queue", 64'(q.size()), 64'd0);
    send(1'b0, 32'h104, 8'd3, 3'd2, 2'b01, 32'h104, 8'd2, 3'd3, 2'b01, 1);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
